// File: rtl/keypad_lock_ctrl_pkg.sv
// Shared definitions for the keypad code-lock controller and the display
// block: lock state encoding, entry-progress base value and special key codes.
package keypad_lock_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WPR  = 2'd1,
    S_OPEN = 2'd2,
    S_LOCK = 2'd3
  } lock_state_e;

  localparam logic [2:0] SL_A    = 3'd0;
  localparam logic [3:0] KEY_CLR = 4'hE;
  localparam logic [3:0] KEY_ENT = 4'hF;

  // Larger of two integers, used to size the shared timer.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/keypad_lock_ctrl_lock_timer.sv
// Loadable down-counter shared by every timed state of the lock controller.
// load has priority over counting; the count stops at zero and done flags it.
module lock_timer #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] count;

  // Count register: reload on request, otherwise decrement until zero.
  // NOTE: sequential state is written with <= so every register samples
  // the pre-edge values of its inputs, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/keypad_lock_ctrl.sv
// Keypad code-lock sequencing FSM. Consumes debounced key strobes, compares
// the entered digits against the stored code and drives the state/progress
// buses for the display block plus the unlock and alarm outputs.
// Optional build macro KEYPAD_CODE_PROGRAM_EN enables re-programming the code
// from the open state (CLEAR, new digits, ENTER).
module keypad_lock_ctrl
  import keypad_lock_ctrl_pkg::*;
#(
  parameter int                  DIGITS         = 4,
  parameter logic [DIGITS*4-1:0] DEFAULT_CODE   = 16'h1234,
  parameter int                  TIMEOUT_CYCLES = 50_000_000,
  parameter int                  OPEN_CYCLES    = 150_000_000,
  parameter int                  MAX_FAIL       = 3,
  parameter int                  LOCK_CYCLES    = 500_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [1:0] ST,
  output logic [2:0] ST_L,
  output logic       unlock,
  output logic       alarm,
  output logic       err_pulse,
  output logic [2:0] fail_cnt
);

  localparam int TW = $clog2(max_int(max_int(TIMEOUT_CYCLES, OPEN_CYCLES), LOCK_CYCLES) + 1);
  localparam logic [TW-1:0] T_KEY  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_OPEN = TW'(OPEN_CYCLES);
  localparam logic [TW-1:0] T_LOCK = TW'(LOCK_CYCLES);
  localparam logic [2:0]    DIG    = 3'(DIGITS);
  localparam logic [2:0]    MAXF   = 3'(MAX_FAIL);

  lock_state_e         state_q, state_d;
  logic [2:0]          pos_q, pos_d;
  logic                mis_q, mis_d;
  logic [2:0]          fail_q, fail_d;
  logic                err_d;
  logic [2:0]          st_l_q, st_l_d;
  logic                unlock_q, alarm_q, err_q;
  logic                tmr_load, tmr_en, tmr_done;
  logic [TW-1:0]       tmr_val;
  logic [DIGITS*4-1:0] code_q;
  logic [3:0]          cur_digit;
  logic                is_digit, is_clr, is_ent;

`ifdef KEYPAD_CODE_PROGRAM_EN
  logic                prog_q, prog_d;
  logic [DIGITS*4-1:0] shadow_q, shadow_d;
  logic [2:0]          pcnt_q, pcnt_d;
  logic                pinv_q, pinv_d;
  logic [DIGITS*4-1:0] code_d;
`else
  assign code_q = DEFAULT_CODE;
`endif

  lock_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .done     (tmr_done)
  );

  assign is_digit = key_valid && (key_code <= 4'd9);
  assign is_clr   = key_valid && (key_code == KEY_CLR);
  assign is_ent   = key_valid && (key_code == KEY_ENT);

  // Select the stored code digit expected at the current entry position.
  always_comb begin
    cur_digit = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      if (pos_q == 3'(i)) cur_digit = code_q[4*(DIGITS-1-i) +: 4];
    end
  end

  // Next-state, entry tracking, timer control and next output values.
  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    mis_d    = mis_q;
    fail_d   = fail_q;
    err_d    = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_en   = 1'b0;
`ifdef KEYPAD_CODE_PROGRAM_EN
    prog_d   = prog_q;
    shadow_d = shadow_q;
    pcnt_d   = pcnt_q;
    pinv_d   = pinv_q;
    code_d   = code_q;
`endif

    case (state_q)
      S_IDLE: begin
        // Timer is parked at zero; the wake key itself is not a digit.
        tmr_load = 1'b1;
        if (key_valid) begin
          state_d = S_WPR;
          pos_d   = '0;
          mis_d   = 1'b0;
          tmr_val = T_KEY;
        end
      end

      S_WPR: begin
        tmr_en = 1'b1;
        if (is_digit) begin
          if (pos_q < DIG) begin
            mis_d = mis_q | (key_code != cur_digit);
            pos_d = pos_q + 3'd1;
          end else begin
            mis_d = 1'b1;
          end
          tmr_load = 1'b1;
          tmr_val  = T_KEY;
        end else if (is_clr) begin
          pos_d    = '0;
          mis_d    = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = T_KEY;
        end else if (is_ent) begin
          pos_d    = '0;
          mis_d    = 1'b0;
          tmr_load = 1'b1;
          if ((pos_q == DIG) && !mis_q) begin
            state_d = S_OPEN;
            fail_d  = '0;
            tmr_val = T_OPEN;
          end else begin
            err_d  = 1'b1;
            fail_d = fail_q + 3'd1;
            if ((fail_q + 3'd1) == MAXF) begin
              state_d = S_LOCK;
              tmr_val = T_LOCK;
            end else begin
              tmr_val = T_KEY;
            end
          end
        end else if (tmr_done) begin
          // Abandoned entry; not counted as a failed attempt.
          state_d  = S_IDLE;
          pos_d    = '0;
          mis_d    = 1'b0;
          tmr_load = 1'b1;
        end
      end

      S_OPEN: begin
        tmr_en = 1'b1;
`ifdef KEYPAD_CODE_PROGRAM_EN
        if (prog_q) begin
          // While programming, the open countdown is suspended and the shared
          // timer measures key inactivity instead; every exit goes to idle.
          if (is_digit) begin
            if (pcnt_q < DIG) begin
              shadow_d = (DIGITS*4)'({shadow_q, key_code});
              pcnt_d   = pcnt_q + 3'd1;
            end else begin
              pinv_d = 1'b1;
            end
            tmr_load = 1'b1;
            tmr_val  = T_KEY;
          end else if (is_ent || tmr_done) begin
            if (is_ent && (pcnt_q == DIG) && !pinv_q) code_d = shadow_q;
            state_d  = S_IDLE;
            prog_d   = 1'b0;
            tmr_load = 1'b1;
          end
        end else if (is_clr) begin
          prog_d   = 1'b1;
          shadow_d = '0;
          pcnt_d   = '0;
          pinv_d   = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = T_KEY;
        end else
`endif
        if (is_ent || tmr_done) begin
          state_d  = S_IDLE;
          tmr_load = 1'b1;
        end
      end

      S_LOCK: begin
        tmr_en = 1'b1;
        if (tmr_done) begin
          state_d  = S_IDLE;
          fail_d   = '0;
          tmr_load = 1'b1;
        end
      end

      default: begin
        state_d  = S_IDLE;
        tmr_load = 1'b1;
      end
    endcase

    // Display progress follows the state being entered.
    st_l_d = SL_A;
    if (state_d == S_WPR) st_l_d = pos_d;
`ifdef KEYPAD_CODE_PROGRAM_EN
    else if ((state_d == S_OPEN) && prog_d) st_l_d = pcnt_d;
`endif
  end

  // State, entry tracking and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pos_q    <= '0;
      mis_q    <= 1'b0;
      fail_q   <= '0;
      err_q    <= 1'b0;
      st_l_q   <= SL_A;
      unlock_q <= 1'b0;
      alarm_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      mis_q    <= mis_d;
      fail_q   <= fail_d;
      err_q    <= err_d;
      st_l_q   <= st_l_d;
      unlock_q <= (state_d == S_OPEN);
      alarm_q  <= (state_d == S_LOCK);
    end
  end

`ifdef KEYPAD_CODE_PROGRAM_EN
  // Programming-mode registers and the stored code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prog_q   <= 1'b0;
      shadow_q <= '0;
      pcnt_q   <= '0;
      pinv_q   <= 1'b0;
      code_q   <= DEFAULT_CODE;
    end else begin
      prog_q   <= prog_d;
      shadow_q <= shadow_d;
      pcnt_q   <= pcnt_d;
      pinv_q   <= pinv_d;
      code_q   <= code_d;
    end
  end
`endif

  assign ST        = state_q;
  assign ST_L      = st_l_q;
  assign unlock    = unlock_q;
  assign alarm     = alarm_q;
  assign err_pulse = err_q;
  assign fail_cnt  = fail_q;

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Self-checking bench for keypad_lock_ctrl (DIGITS=4, code 1234, short timers).
// A vector table covers the main entry paths; hand-written sequences cover
// timeout, expiry-cycle key, lockout, open duration and mid-entry reset.
module tb_keypad_lock_ctrl;

  localparam int TMO = 8;
  localparam int OPN = 6;
  localparam int LCK = 10;

  localparam logic [1:0] SI = 2'd0, SW = 2'd1, SO = 2'd2, SL = 2'd3;
  localparam logic [3:0] K_CLR = 4'hE, K_ENT = 4'hF;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic [1:0] ST;
  logic [2:0] ST_L;
  logic       unlock, alarm, err_pulse;
  logic [2:0] fail_cnt;

  keypad_lock_ctrl #(
    .DIGITS(4), .DEFAULT_CODE(16'h1234), .TIMEOUT_CYCLES(TMO),
    .OPEN_CYCLES(OPN), .MAX_FAIL(3), .LOCK_CYCLES(LCK)
  ) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .ST(ST), .ST_L(ST_L), .unlock(unlock), .alarm(alarm),
    .err_pulse(err_pulse), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] st;
    logic [2:0] stl;
    logic       unl;
    logic       alm;
    logic       err;
    logic [2:0] fc;
  } exp_t;

  typedef struct packed {
    logic       kv;
    logic [3:0] kc;
    exp_t       e;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[24];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic exp_t ex(input logic [1:0] s, input logic [2:0] l, input logic u,
                              input logic a, input logic r, input logic [2:0] f);
    exp_t e;
    e.st = s; e.stl = l; e.unl = u; e.alm = a; e.err = r; e.fc = f;
    return e;
  endfunction

  function automatic exp_t w(input logic [2:0] l, input logic [2:0] f);
    return ex(SW, l, 1'b0, 1'b0, 1'b0, f);
  endfunction

  function automatic vec_t v(input logic kv, input logic [3:0] kc, input exp_t e);
    vec_t r;
    r.kv = kv; r.kc = kc; r.e = e;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s got %0d want %0d", name, act, req);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    check({tag, ".ST"},        int'(ST),        int'(e.st));
    check({tag, ".ST_L"},      int'(ST_L),      int'(e.stl));
    check({tag, ".unlock"},    int'(unlock),    int'(e.unl));
    check({tag, ".alarm"},     int'(alarm),     int'(e.alm));
    check({tag, ".err_pulse"}, int'(err_pulse), int'(e.err));
    check({tag, ".fail_cnt"},  int'(fail_cnt),  int'(e.fc));
  endtask

  // Drive one strobe (or idle cycle), queue its expectation, compare after the edge.
  task automatic step(input logic kv, input logic [3:0] kc, input exp_t e, input string tag);
    exp_t got;
    @(negedge clk);
    key_valid = kv;
    key_code  = kc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    if (sb.size() == 0) begin
      check({tag, ".queue"}, 0, 1);
    end else begin
      got = sb.pop_front();
      check_all(tag, got);
    end
  endtask

  task automatic idle(input exp_t e, input string tag);
    step(1'b0, 4'h0, e, tag);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    tbl[0]  = v(1, 4'h5,  w(0, 0));
    tbl[1]  = v(1, 4'h1,  w(1, 0));
    tbl[2]  = v(1, 4'h2,  w(2, 0));
    tbl[3]  = v(1, 4'h4,  w(3, 0));
    tbl[4]  = v(1, 4'h4,  w(4, 0));
    tbl[5]  = v(1, K_ENT, ex(SW, 0, 0, 0, 1, 1));
    tbl[6]  = v(0, 4'h0,  w(0, 1));
    tbl[7]  = v(1, 4'h1,  w(1, 1));
    tbl[8]  = v(1, 4'h2,  w(2, 1));
    tbl[9]  = v(1, 4'h3,  w(3, 1));
    tbl[10] = v(1, 4'h4,  w(4, 1));
    tbl[11] = v(1, 4'h5,  w(4, 1));
    tbl[12] = v(1, K_ENT, ex(SW, 0, 0, 0, 1, 2));
    tbl[13] = v(1, 4'h1,  w(1, 2));
    tbl[14] = v(1, 4'hA,  w(1, 2));
    tbl[15] = v(1, K_CLR, w(0, 2));
    tbl[16] = v(1, 4'h1,  w(1, 2));
    tbl[17] = v(1, 4'h2,  w(2, 2));
    tbl[18] = v(1, 4'h3,  w(3, 2));
    tbl[19] = v(1, 4'h4,  w(4, 2));
    tbl[20] = v(1, K_ENT, ex(SO, 0, 1, 0, 0, 0));
    tbl[21] = v(1, 4'h7,  ex(SO, 0, 1, 0, 0, 0));
    tbl[22] = v(1, K_CLR, ex(SO, 0, 1, 0, 0, 0));
    tbl[23] = v(1, K_ENT, ex(SI, 0, 0, 0, 0, 0));

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", ex(SI, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;

    // Table: wrong code, extra digit, ignored key, CLEAR, correct code, relock.
    for (int i = 0; i < 24; i++) begin
      step(tbl[i].kv, tbl[i].kc, tbl[i].e, $sformatf("vec%0d", i));
    end

    // Timeout abandons entry without counting a failure.
    step(1, 4'h5,  w(0, 0), "to_wake");
    step(1, K_ENT, ex(SW, 0, 0, 0, 1, 1), "to_fail");
    step(1, 4'h1,  w(1, 1), "to_d1");
    step(1, 4'h2,  w(2, 1), "to_d2");
    for (int i = 0; i < TMO; i++) idle(w(2, 1), $sformatf("to_wait%0d", i));
    idle(ex(SI, 0, 0, 0, 0, 1), "to_expire");

    // Key on the exact expiry cycle is processed.
    step(1, 4'h7,  w(0, 1), "ex_wake");
    step(1, 4'h1,  w(1, 1), "ex_d1");
    step(1, 4'h2,  w(2, 1), "ex_d2");
    for (int i = 0; i < TMO; i++) idle(w(2, 1), $sformatf("ex_wait%0d", i));
    step(1, 4'h3,  w(3, 1), "ex_key");

    // Two more failures reach lockout; keys ignored; expiry clears fail_cnt.
    step(1, K_ENT, ex(SW, 0, 0, 0, 1, 2), "lk_fail2");
    step(1, K_ENT, ex(SL, 0, 0, 1, 1, 3), "lk_fail3");
    step(1, 4'h1,  ex(SL, 0, 0, 1, 0, 3), "lk_key");
    step(1, K_ENT, ex(SL, 0, 0, 1, 0, 3), "lk_ent");
    for (int i = 0; i < LCK - 2; i++) idle(ex(SL, 0, 0, 1, 0, 3), $sformatf("lk_wait%0d", i));
    idle(ex(SI, 0, 0, 0, 0, 0), "lk_expire");

    // Open duration.
    step(1, 4'h5, w(0, 0), "op_wake");
    step(1, 4'h1, w(1, 0), "op_d1");
    step(1, 4'h2, w(2, 0), "op_d2");
    step(1, 4'h3, w(3, 0), "op_d3");
    step(1, 4'h4, w(4, 0), "op_d4");
    step(1, K_ENT, ex(SO, 0, 1, 0, 0, 0), "op_ent");
    for (int i = 0; i < OPN; i++) idle(ex(SO, 0, 1, 0, 0, 0), $sformatf("op_wait%0d", i));
    idle(ex(SI, 0, 0, 0, 0, 0), "op_expire");

    // Reset in the middle of an entry with a nonzero failure count.
    step(1, 4'h5,  w(0, 0), "rs_wake");
    step(1, K_ENT, ex(SW, 0, 0, 0, 1, 1), "rs_fail");
    step(1, 4'h1,  w(1, 1), "rs_d1");
    step(1, 4'h2,  w(2, 1), "rs_d2");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all("rs_async", ex(SI, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    idle(ex(SI, 0, 0, 0, 0, 0), "rs_after");
    step(1, 4'h3, w(0, 0), "rs_wake2");
    step(1, 4'h1, w(1, 0), "rs_d1b");

`ifdef KEYPAD_CODE_PROGRAM_EN
    // Program code 9876 from the open state, then verify old and new codes.
    step(1, K_CLR, w(0, 0), "pg_clr0");
    step(1, 4'h1, w(1, 0), "pg_a1");
    step(1, 4'h2, w(2, 0), "pg_a2");
    step(1, 4'h3, w(3, 0), "pg_a3");
    step(1, 4'h4, w(4, 0), "pg_a4");
    step(1, K_ENT, ex(SO, 0, 1, 0, 0, 0), "pg_open");
    step(1, K_CLR, ex(SO, 0, 1, 0, 0, 0), "pg_clr");
    step(1, 4'h9, ex(SO, 1, 1, 0, 0, 0), "pg_n9");
    step(1, 4'h8, ex(SO, 2, 1, 0, 0, 0), "pg_n8");
    step(1, 4'h7, ex(SO, 3, 1, 0, 0, 0), "pg_n7");
    step(1, 4'h6, ex(SO, 4, 1, 0, 0, 0), "pg_n6");
    step(1, K_ENT, ex(SI, 0, 0, 0, 0, 0), "pg_commit");
    step(1, 4'h5, w(0, 0), "pg_wake");
    step(1, 4'h1, w(1, 0), "pg_o1");
    step(1, 4'h2, w(2, 0), "pg_o2");
    step(1, 4'h3, w(3, 0), "pg_o3");
    step(1, 4'h4, w(4, 0), "pg_o4");
    step(1, K_ENT, ex(SW, 0, 0, 0, 1, 1), "pg_oldfail");
    step(1, 4'h9, w(1, 1), "pg_m9");
    step(1, 4'h8, w(2, 1), "pg_m8");
    step(1, 4'h7, w(3, 1), "pg_m7");
    step(1, 4'h6, w(4, 1), "pg_m6");
    step(1, K_ENT, ex(SO, 0, 1, 0, 0, 0), "pg_newopen");
    step(1, K_ENT, ex(SI, 0, 0, 0, 0, 0), "pg_relock");
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
